// File: rtl/pixel_fetch_sched.sv
// Line-buffer refill scheduler: walks one line of external pixel memory per
// line_start, realigns returned nibbles to the read latency and writes them into the idle buffer half.
module pixel_fetch_sched #(
  parameter int H_PIXELS = 160,
  parameter int ADDR_W   = 9,
  parameter int RD_LAT   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic                      swap_req,
  input  logic [3:0]                pixel_in,
  output logic [ADDR_W-1:0]         addr,
  output logic [2:0]                pix_sel,
  output logic                      bank,
  output logic                      buf_we,
  output logic [$clog2(H_PIXELS):0] buf_waddr,
  output logic [3:0]                buf_wdata,
  output logic                      rd_half,
  output logic                      line_done,
  output logic                      busy,
  output logic                      underrun,
  output logic [1:0]                state_dbg
);

  localparam int PC_W = $clog2(H_PIXELS);
  localparam logic [RD_LAT-1:0] OUT_MASK = RD_LAT'(1) << (RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] word_ptr;
  logic              issue_v;
  logic [PC_W-1:0]   issue_pc;
  logic [RD_LAT-1:0] tag_v;
  logic [PC_W-1:0]   tag_pc [RD_LAT];

  logic              start;
  logic              do_issue;
  logic [PC_W-1:0]   iss_pc;
  logic [ADDR_W-1:0] wp_base;
  logic [ADDR_W-1:0] wp_next;
  logic              drain_done;

  assign state_dbg = state;

  // buf_we is a one-cycle write strobe with no back-pressure: buf_waddr and
  // buf_wdata are meaningful only while it is high and read zero otherwise.
  assign buf_we    = tag_v[RD_LAT-1];
  assign buf_waddr = buf_we ? {~rd_half, tag_pc[RD_LAT-1]} : '0;
  assign buf_wdata = buf_we ? pixel_in : 4'd0;

  always_comb begin
    start      = line_start && ena;
    do_issue   = start || (state == ST_FETCH);
    iss_pc     = start ? '0 : pc;
    // frame_start takes effect before any issue in the same cycle
    wp_base    = frame_start ? '0 : word_ptr;
    wp_next    = (do_issue && (iss_pc[2:0] == 3'd7)) ? wp_base + ADDR_W'(1) : wp_base;
    drain_done = !issue_v && ((tag_v & ~OUT_MASK) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= '0;
      word_ptr  <= '0;
      issue_v   <= 1'b0;
      issue_pc  <= '0;
      tag_v     <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_pc[k] <= '0;
      addr      <= '0;
      pix_sel   <= 3'd0;
      bank      <= 1'b0;
      rd_half   <= 1'b0;
      line_done <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      line_done <= 1'b0;
      word_ptr  <= wp_next;
      if (frame_start) begin
        underrun <= 1'b0;
        if (swap_req) bank <= ~bank;
      end

      tag_v[0]  <= issue_v;
      tag_pc[0] <= issue_pc;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_pc[k] <= tag_pc[k-1];
      end

      if (do_issue) begin
        issue_v  <= 1'b1;
        issue_pc <= iss_pc;
        addr     <= wp_base;
        pix_sel  <= iss_pc[2:0];
        pc       <= iss_pc + PC_W'(1);
      end else begin
        issue_v  <= 1'b0;
      end

      if (start) begin
        state   <= ST_FETCH;
        busy    <= 1'b1;
        rd_half <= ~rd_half;
        // A request while busy aborts the line; in-flight captures are dropped.
        if (state != ST_IDLE) begin
          underrun <= 1'b1;
          tag_v    <= '0;
        end
      end else begin
        case (state)
          ST_FETCH: begin
            if (iss_pc == PC_W'(H_PIXELS - 1)) state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (drain_done) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              line_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch_sched.sv
// Directed bench for pixel_fetch_sched: a latency-modelled external memory,
// a write/line_done scoreboard fed by the stimulus tasks, and a summary report.
module tb_pixel_fetch_sched;

  localparam int H      = 16;
  localparam int ADDR_W = 9;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(H) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              frame_start = 1'b0;
  logic              line_start = 1'b0;
  logic              swap_req = 1'b0;
  logic [3:0]        pixel_in;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        pix_sel;
  logic              bank;
  logic              buf_we;
  logic [AW-1:0]     buf_waddr;
  logic [3:0]        buf_wdata;
  logic              rd_half;
  logic              line_done;
  logic              busy;
  logic              underrun;
  logic [1:0]        state_dbg;

  int cyc = 0;
  int checks = 0;
  int fails = 0;

  // {write cycle[15:0], waddr[4:0], wdata[3:0]}
  logic [24:0] exp_q[$];
  int          done_q[$];

  bit          mhalf = 1'b0;
  bit          mbank = 1'b0;
  bit          mund  = 1'b0;
  logic [8:0]  mwp   = '0;

  logic [3:0]  mem_pipe [RD_LAT] = '{default: 4'd0};

  pixel_fetch_sched #(.H_PIXELS(H), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_start(frame_start),
    .line_start(line_start), .swap_req(swap_req), .pixel_in(pixel_in),
    .addr(addr), .pix_sel(pix_sel), .bank(bank), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .rd_half(rd_half),
    .line_done(line_done), .busy(busy), .underrun(underrun), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external memory: returns {addr[0], pix_sel} RD_LAT cycles after issue
  always @(posedge clk) begin
    mem_pipe[0] <= {addr[0], pix_sel};
    for (int k = 1; k < RD_LAT; k++) mem_pipe[k] <= mem_pipe[k-1];
  end
  assign pixel_in = mem_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (buf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write at cycle %0d: got waddr 0x%0h data 0x%0h expected no write",
                 cyc, buf_waddr, buf_wdata);
      end else begin
        check("buf_write", 32'({cyc[15:0], buf_waddr, buf_wdata}), 32'(exp_q.pop_front()));
      end
    end
    if (line_done) begin
      if (done_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_line_done at cycle %0d: got pulse expected none", cyc);
      end else begin
        check("line_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic step_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_pix_sel"}, 32'(pix_sel), 32'd0);
    check({tag, "_bank"}, 32'(bank), 32'd0);
    check({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    check({tag, "_buf_waddr"}, 32'(buf_waddr), 32'd0);
    check({tag, "_buf_wdata"}, 32'(buf_wdata), 32'd0);
    check({tag, "_rd_half"}, 32'(rd_half), 32'd0);
    check({tag, "_line_done"}, 32'(line_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // Drive one line_start (optionally with frame_start) at the current negedge,
  // push the expected writes, and check the first fetch cycle.
  task automatic start_line(input bit fs, input bit sr, input int n_wr, input bit push_done,
                            input int adv, input bit during_busy,
                            output int t, output logic [8:0] w0);
    logic [8:0] word;
    logic [3:0] i4;
    if (fs) begin
      mwp = '0;
      mund = 1'b0;
      if (sr) mbank = ~mbank;
    end
    if (during_busy) mund = 1'b1;
    mhalf = ~mhalf;
    t = cyc;
    w0 = mwp;
    for (int i = 0; i < n_wr; i++) begin
      word = mwp + 9'(i / 8);
      i4 = 4'(i);
      exp_q.push_back({16'(t + 1 + i + RD_LAT), ~mhalf, i4, word[0], i4[2:0]});
    end
    if (push_done) done_q.push_back(t + H + RD_LAT + 1);
    mwp = mwp + 9'(adv);
    line_start = 1'b1;
    frame_start = fs;
    swap_req = sr;
    @(negedge clk);
    line_start = 1'b0;
    frame_start = 1'b0;
    swap_req = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_rd_half", 32'(rd_half), 32'(mhalf));
    check("start_bank", 32'(bank), 32'(mbank));
    check("start_underrun", 32'(underrun), 32'(mund));
    check("start_addr", 32'(addr), 32'(w0));
    check("start_pix_sel", 32'(pix_sel), 32'd0);
  endtask

  task automatic finish_line(input int t, input logic [8:0] w0);
    step_to(t + 9);
    check("second_word_addr", 32'(addr), 32'(9'(w0 + 9'd1)));
    check("second_word_pix_sel", 32'(pix_sel), 32'd0);
    step_to(t + H + RD_LAT);
    check("busy_before_done", 32'(busy), 32'd1);
    step_to(t + H + RD_LAT + 1);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic frame_pulse(input bit sr);
    frame_start = 1'b1;
    swap_req = sr;
    mwp = '0;
    mund = 1'b0;
    if (sr) mbank = ~mbank;
    @(negedge clk);
    frame_start = 1'b0;
    swap_req = 1'b0;
    check("frame_bank", 32'(bank), 32'(mbank));
    check("frame_underrun", 32'(underrun), 32'(mund));
    check("frame_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    checks++;
    fails++;
    $display("FAIL watchdog at cycle %0d: got no end of test expected completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int t;
    int t2;
    logic [8:0] w;
    logic [8:0] w2;

    // reset held three cycles, then twenty idle cycles
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // frame start with first line, then two back-to-back lines in the same frame
    start_line(1'b1, 1'b0, H, 1'b1, 2, 1'b0, t, w);
    finish_line(t, w);
    start_line(1'b0, 1'b0, H, 1'b1, 2, 1'b0, t, w);
    finish_line(t, w);
    start_line(1'b0, 1'b0, H, 1'b1, 2, 1'b0, t, w);
    finish_line(t, w);
    repeat (3) @(negedge clk);

    // bank swap at frame start, then a frame start without swap
    start_line(1'b1, 1'b1, H, 1'b1, 2, 1'b0, t, w);
    finish_line(t, w);
    repeat (2) @(negedge clk);
    frame_pulse(1'b0);
    repeat (2) @(negedge clk);

    // underrun: second request eight cycles into a fetch
    start_line(1'b0, 1'b0, 6, 1'b0, 1, 1'b0, t, w);
    step_to(t + 8);
    check("underrun_before", 32'(underrun), 32'd0);
    start_line(1'b0, 1'b0, H, 1'b1, 2, 1'b1, t2, w2);
    finish_line(t2, w2);
    repeat (2) @(negedge clk);
    check("underrun_sticky", 32'(underrun), 32'd1);
    frame_pulse(1'b0);

    // ena low gates line_start
    ena = 1'b0;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (10) begin
      check("gated_busy", 32'(busy), 32'd0);
      check("gated_rd_half", 32'(rd_half), 32'(mhalf));
      @(negedge clk);
    end
    ena = 1'b1;

    // reset mid-fetch at pixel 5
    start_line(1'b0, 1'b0, 4, 1'b0, 0, 1'b0, t, w);
    step_to(t + 6);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_buf_we", 32'(buf_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    check_reset_outputs("midrst");
    mhalf = 1'b0;
    mbank = 1'b0;
    mund = 1'b0;
    mwp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full line after reset recovery
    start_line(1'b0, 1'b0, H, 1'b1, 2, 1'b0, t, w);
    finish_line(t, w);
    repeat (5) @(negedge clk);

    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("line_done_outstanding", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pixel_fetch_sched.md
# pixel_fetch_sched

Scheduler that refills the on-chip ping-pong line buffer from the external pixel memory over the narrow pin interface. The external memory is addressed by `addr`/`bank`/`pix_sel` and returns a 4-bit pixel on `pixel_in`. On each line-start request from the video timing, the block walks one line of pixels, realigns the returned nibbles to the fixed read latency and writes them into the idle half of the line buffer. It also owns frame-bank swapping and underrun detection. It sits between the video timing generator and the pixel pins, in the `clk_video` domain.

## Interface
- `H_PIXELS`, 160: pixels fetched per line; must be a multiple of 8.
- `ADDR_W`, 9: external word address width.
- `RD_LAT`, 2: cycles from `addr`/`pix_sel` driven to `pixel_in` valid; range 1..4.
- `clk` in 1: pixel clock; this is the `clk_video` domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: when low, no new line fetch starts; an active fetch completes.
- `frame_start` in 1: one-cycle pulse at the first line of a frame.
- `line_start` in 1: one-cycle pulse requesting the fetch of the next line.
- `swap_req` in 1: level; request a frame-bank swap at the next `frame_start`.
- `pixel_in` in 4: pixel returned by the external memory.
- `addr` out ADDR_W: external word address.
- `pix_sel` out 3: pixel index within the word.
- `bank` out 1: external frame bank being read.
- `buf_we` out 1: line-buffer write strobe.
- `buf_waddr` out 1+clog2(H_PIXELS): `{wr_half, pixel_index}`.
- `buf_wdata` out 4: pixel written.
- `rd_half` out 1: line-buffer half owned by the display; the opposite half is being written.
- `line_done` out 1: one-cycle pulse when a line fetch completes.
- `busy` out 1: high while in FETCH or DRAIN.
- `underrun` out 1: sticky; cleared only by reset or `frame_start`.

## Operation
- States: IDLE, FETCH, DRAIN.
- **IDLE → FETCH.** Taken on `line_start` && `ena`. In the same cycle:
  - toggle `rd_half`; the half just filled becomes displayed;
  - clear the pixel counter `pc` to 0.
- **FETCH.** Each cycle:
  - drive `addr = word_ptr`, `pix_sel = pc[2:0]`;
  - push `{valid, pc}` into an RD_LAT-deep tag shift register;
  - increment `pc`;
  - when `pc[2:0]` wraps 7→0, increment `word_ptr`, wrapping modulo 2^ADDR_W.
- **FETCH → DRAIN.** Taken after issuing `pc = H_PIXELS-1`.
- **DRAIN.** No new issues; `addr`/`pix_sel` hold their last values. Leave for IDLE when the tag pipe is empty, pulsing `line_done` on that transition.
- **Capture.**
  - Whenever the tag-pipe output is valid: `buf_we = 1`, `buf_wdata = pixel_in`, `buf_waddr = {~rd_half, tag_pc}`.
  - Writes are unregistered relative to the tag pipe, so `pixel_in` is sampled exactly RD_LAT cycles after issue.
- **`frame_start`.**
  - Resets `word_ptr` to 0 and clears `underrun`.
  - If `swap_req` is high, toggles `bank`.
  - Neither `bank` nor `word_ptr` changes at any other time.
  - If `frame_start` and `line_start` coincide, the `frame_start` updates apply first: that line is fetched from word 0 of the new bank.
- **Underrun.** On `line_start` while `busy`:
  - set `underrun`;
  - flush the tag pipe, discarding in-flight captures;
  - restart FETCH with `pc = 0` and toggle `rd_half`;
  - `word_ptr` continues from its current value;
  - no `line_done` is issued for the aborted line.
- **`ena` low at `line_start`.** The request is ignored; no toggle, no flag.
- **Reset outputs.** `addr=0`, `pix_sel=0`, `bank=0`, `buf_we=0`, `buf_waddr=0`, `buf_wdata=0`, `rd_half=0`, `line_done=0`, `busy=0`, `underrun=0`. The state returns to IDLE and the tag pipe clears.
- **Reset mid-fetch.** Same result; no write strobe on the cycle after reset is asserted.

## Timing
- `line_start` sampled at cycle T:
  - `busy` = 1 from T+1;
  - pixel i issued at T+1+i;
  - pixel i written at T+1+i+RD_LAT.
- Last write: T+H_PIXELS+RD_LAT.
- `line_done`: T+H_PIXELS+RD_LAT+1, together with `busy` falling.
- Fetch footprint: H_PIXELS+RD_LAT+1 cycles. This must fit in one line period or an underrun results.
- Back-to-back: a `line_start` on the `line_done` cycle is legal (state is IDLE) and starts a new fetch at the next cycle.
- `rd_half` toggles on the cycle after `line_start` is sampled.
- `bank` toggles on the cycle after `frame_start` is sampled.

## Test plan
- **Reset.** Hold `rst_n=0` 3 cycles, then release. All outputs at reset values; `busy=0` for 20 idle cycles.
- **Single line, H_PIXELS=16, RD_LAT=2.** `frame_start`+`line_start` at T=10; memory model returns `pixel_in = {addr[0], pix_sel}`.
  - 16 writes at T=13..28 to addresses {1, 0..15};
  - data 0..7, then 8..15;
  - `addr` 0 then 1;
  - `line_done` at T=29.
- **Word pointer across lines.** Three lines in one frame → `addr` sequence 0,1 / 2,3 / 4,5. Next `frame_start` restarts at 0. `rd_half` alternates 1,0,1.
- **Bank swap.** `swap_req=1` at `frame_start` → `bank` 0→1. `swap_req=0` at the next `frame_start` → `bank` holds 1.
- **Underrun.** Second `line_start` 8 cycles after the first.
  - `underrun=1`;
  - no `line_done` for the first line;
  - no write reaches the buffer from tags issued before the restart;
  - 16 fresh writes follow.
  - `frame_start` clears `underrun`.
- **Gating and reset mid-fetch.**
  - `line_start` with `ena=0` → no activity.
  - `rst_n` pulled low at pixel 5 → next cycle `buf_we=0`, `busy=0`, `addr=0`.
